// File: rtl/clint_arb_pkg.sv
// rtl/clint_arb_pkg.sv - shared FSM encoding, defaults and helpers for the CLINT arbiter
package clint_arb_pkg;

    // Arbiter transaction phases; one transaction outstanding at a time.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Watchdog limit in cycles; must exceed the slowest slave latency.
    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    // Supported requester count range.
    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 8;

    // Width of a requester index; never zero so single-bit vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clint_rr_picker.sv
// rtl/clint_rr_picker.sv - combinational round-robin selector: first request at or after ptr
module clint_rr_picker
    import clint_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    // Candidate position walking cyclically from ptr; one extra bit so the
    // wrap test works for non-power-of-two requester counts.
    logic [IDX_W:0] cand;

    // Scan N_REQ positions starting at ptr and keep the first active one.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N_REQ)) begin
                cand = cand - (IDX_W + 1)'(N_REQ);
            end
            if (!any && req[cand[IDX_W-1:0]]) begin
                any                     = 1'b1;
                index                   = cand[IDX_W-1:0];
                grant[cand[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clint_arbiter.sv
// rtl/clint_arbiter.sv - round-robin arbiter sharing one CLINT port; CLINT_ARB_TIMEOUT_EN adds a response watchdog
module clint_arbiter
    import clint_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_W-1:0]     req_address,
    input  logic [N_REQ*DATA_W-1:0]     req_wdata,
    input  logic [N_REQ*(DATA_W/8)-1:0] req_wstrb,
    output logic [N_REQ*DATA_W-1:0]     req_rdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            req_err,
    output logic                        m_valid,
    output logic [ADDR_W-1:0]           m_address,
    output logic [DATA_W-1:0]           m_wdata,
    output logic [DATA_W/8-1:0]         m_wstrb,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic                        m_ready
);

    localparam int IDX_W  = idx_width(N_REQ);
    localparam int STRB_W = DATA_W / 8;

    // Reject configurations the requester index and slicing cannot support.
    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("clint_arbiter: parameter out of range");
    end

    arb_state_t          state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    gidx;
    logic [IDX_W-1:0]    next_ptr;

    logic [N_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]    pick_index;
    logic                pick_any;

    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;

`ifdef CLINT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    wait_cnt;
    logic [N_REQ-1:0]    err_q;
    assign req_err = err_q;
`else
    assign req_err = '0;
`endif

    clint_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .index (pick_index),
        .any   (pick_any)
    );

    // Priority restarts just after the requester served last.
    assign next_ptr = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    // One-hot AND-OR mux of the winning requester's fields.
    always_comb begin
        sel_address = '0;
        sel_wdata   = '0;
        sel_wstrb   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_address = sel_address | req_address[i*ADDR_W +: ADDR_W];
                sel_wdata   = sel_wdata   | req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb   = sel_wstrb   | req_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // Transaction FSM with registered master and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gidx      <= '0;
            m_valid   <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            req_ready <= '0;
            req_rdata <= '0;
`ifdef CLINT_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= '0;
`endif
        end else begin
            req_ready <= '0;
`ifdef CLINT_ARB_TIMEOUT_EN
            err_q     <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gidx      <= pick_index;
                        m_address <= sel_address;
                        m_wdata   <= sel_wdata;
                        m_wstrb   <= sel_wstrb;
                        m_valid   <= 1'b1;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    m_valid <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_ready) begin
                        req_rdata[gidx*DATA_W +: DATA_W] <= m_rdata;
                        req_ready[gidx]                  <= 1'b1;
                        state                            <= ST_RESP;
`ifdef CLINT_ARB_TIMEOUT_EN
                        wait_cnt                         <= '0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        req_rdata[gidx*DATA_W +: DATA_W] <= '1;
                        req_ready[gidx]                  <= 1'b1;
                        err_q[gidx]                      <= 1'b1;
                        state                            <= ST_RESP;
                        wait_cnt                         <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    ptr   <= next_ptr;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
